// File: rtl/hazard_stall_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hazard_pkg
// Brief    : Shared types for the decode-stage hazard scheduler.
// Revision : 1.0
// ============================================================================
package hazard_pkg;

    localparam int REG_W = 3;

    typedef struct packed {
        logic             v;
        logic [REG_W-1:0] rd;
        logic             ld;
    } slot_t;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_STALL  = 2'd1,
        ST_FREEZE = 2'd2
    } state_t;

    localparam slot_t SLOT_EMPTY = '0;

endpackage
`default_nettype wire

// File: rtl/hazard_slot_match.sv
`default_nettype none
// ============================================================================
// Module   : hazard_slot_match
// Brief    : Compares one used source register against one in-flight slot.
// Revision : 1.0
// ============================================================================
module hazard_slot_match
    import hazard_pkg::*;
(
    input  slot_t            slot_i,
    input  logic [REG_W-1:0] src_i,
    input  logic             src_used_i,
    output logic             match_o
);

    assign match_o = slot_i.v & src_used_i & (slot_i.rd == src_i);

endmodule
`default_nettype wire

// File: rtl/hazard_stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hazard_stall_ctrl
// Brief    : Decode-stage issue/stall/freeze scheduler tracking EX/MEM/WB rd.
// Revision : 1.0
// ============================================================================
module hazard_stall_ctrl
    import hazard_pkg::*;
#(
    parameter bit FWD_EN = 1'b0,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs,
    input  logic             id_rs_used,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_rt_used,
    input  logic [REG_W-1:0] id_rd,
    input  logic             id_rd_write,
    input  logic             id_is_load,
    input  logic             flush,
    input  logic             mem_busy,
    output logic             stall,
    output logic             freeze,
    output logic             issue,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_cnt
);

    slot_t            ex_q, mem_q, wb_q;
    slot_t            ex_d, mem_d, wb_d;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             haz;
    logic             unused_wb;

    // WB never stalls (register file writes before it reads), so only EX/MEM are compared
    generate
        if (FWD_EN) begin : g_fwd
            logic rs_ex, rt_ex;
            hazard_slot_match u_rs_ex (.slot_i(ex_q), .src_i(id_rs), .src_used_i(id_rs_used), .match_o(rs_ex));
            hazard_slot_match u_rt_ex (.slot_i(ex_q), .src_i(id_rt), .src_used_i(id_rt_used), .match_o(rt_ex));
            assign haz = id_valid & (rs_ex | rt_ex) & ex_q.ld;
        end else begin : g_nofwd
            logic rs_ex, rt_ex, rs_mem, rt_mem;
            hazard_slot_match u_rs_ex  (.slot_i(ex_q),  .src_i(id_rs), .src_used_i(id_rs_used), .match_o(rs_ex));
            hazard_slot_match u_rt_ex  (.slot_i(ex_q),  .src_i(id_rt), .src_used_i(id_rt_used), .match_o(rt_ex));
            hazard_slot_match u_rs_mem (.slot_i(mem_q), .src_i(id_rs), .src_used_i(id_rs_used), .match_o(rs_mem));
            hazard_slot_match u_rt_mem (.slot_i(mem_q), .src_i(id_rt), .src_used_i(id_rt_used), .match_o(rt_mem));
            assign haz = id_valid & (rs_ex | rt_ex | rs_mem | rt_mem);
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q    <= SLOT_EMPTY;
            mem_q   <= SLOT_EMPTY;
            wb_q    <= SLOT_EMPTY;
            state_q <= ST_RUN;
            cnt_q   <= '0;
        end else begin
            ex_q    <= ex_d;
            mem_q   <= mem_d;
            wb_q    <= wb_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        ex_d  = ex_q;
        mem_d = mem_q;
        wb_d  = wb_q;
        if (!freeze) begin
            wb_d  = mem_q;
            mem_d = ex_q;
            ex_d  = SLOT_EMPTY;
            if (issue && id_rd_write) begin
                ex_d = {1'b1, id_rd, id_is_load};
            end
        end

        if (mem_busy) begin
            state_d = ST_FREEZE;
        end else if (stall) begin
            state_d = ST_STALL;
        end else begin
            state_d = ST_RUN;
        end

        cnt_d = cnt_q;
        if (stall && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_comb begin
        freeze = mem_busy;
        stall  = 1'b0;
        issue  = 1'b0;
        if (!mem_busy && !flush) begin
            if (haz) begin
                stall = 1'b1;
            end else begin
                issue = id_valid;
            end
        end
    end

    assign state     = state_q;
    assign stall_cnt = cnt_q;
    assign unused_wb = ^wb_q;

endmodule
`default_nettype wire
